// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// The optional bus-error check is enabled by defining DMEM_BUS_ERR_EN.
package dmem_pkg;

  localparam int unsigned DEFAULT_DEPTH       = 1024;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam int unsigned IDX_W               = 30;  // full word index of a 32-bit byte address

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             wr_en;
    logic [3:0]       mask;
    logic [IDX_W-1:0] index;
    logic [31:0]      data;
    logic             err;
  } req_t;

endpackage

// File: rtl/dmem_byte_array.sv
// Word array with per-byte write enables and a registered read port.
module dmem_byte_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        we_i,
  input  logic              rd_en_i,
  input  logic              rd_zero_i,
  input  logic [ADDR_W-1:0] index_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // NOTE: the storage array has no reset branch; clearing it would turn the
  // block RAM into thousands of flops, and its power-up contents are undefined.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[index_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= rd_zero_i ? '0 : mem_q[index_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle LSU data memory with WAIT_CYCLES wait states and a one-cycle
// mem_ready pulse. Define DMEM_BUS_ERR_EN to enable out-of-range/bad-write errors.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        wr_en,
  input  logic [3:0]  mask,
  input  logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_inData,
  output logic [31:0] Mem_outData,
  output logic        mem_ready,
  output logic        busy,
  output logic        bus_err
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       req_q, req_in, req_cur;
  logic       commit;
  logic       unused_bits;

  always_comb begin
    req_in.wr_en = wr_en;
    req_in.mask  = mask;
    req_in.index = Mem_Addr[31:2];
    req_in.data  = Mem_inData;
`ifdef DMEM_BUS_ERR_EN
    req_in.err   = ((Mem_Addr[31:2] >> ADDR_W) != '0) ||
                   (wr_en && (mask == 4'b0) && (Mem_Addr[1:0] != 2'b0));
`else
    req_in.err   = 1'b0;
`endif
  end

  // With zero wait states the commit happens on the accepting edge, so the
  // array must see the live request rather than the latched copy.
  assign req_cur = (state_q == IDLE) ? req_in : req_q;

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs) begin
          cnt_d = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && cs) req_q <= req_in;
    end
  end

  logic [3:0] arr_we;
  logic       arr_rd_en;

  // Reset on the commit edge discards the pending write.
  assign arr_we    = (commit && !reset && req_cur.wr_en && !req_cur.err) ? req_cur.mask : 4'b0;
  assign arr_rd_en = commit && !req_cur.wr_en;

  dmem_byte_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .we_i      (arr_we),
    .rd_en_i   (arr_rd_en),
    .rd_zero_i (req_cur.err),
    .index_i   (req_cur.index[ADDR_W-1:0]),
    .wdata_i   (req_cur.data),
    .rdata_o   (Mem_outData)
  );

  assign mem_ready = (state_q == RESP);
  assign busy      = (state_q != IDLE);
`ifdef DMEM_BUS_ERR_EN
  assign bus_err   = mem_ready & req_q.err;
`else
  assign bus_err   = 1'b0;
`endif

  assign unused_bits = ^{Mem_Addr[1:0], req_cur.index >> ADDR_W};

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: instance 1 runs WAIT_CYCLES=2, instance 0 runs WAIT_CYCLES=0.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs        [2];
  logic        wr_en     [2];
  logic [3:0]  mask      [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [31:0] mem_out   [2];
  logic        mem_ready [2];
  logic        busy      [2];
  logic        bus_err   [2];

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] last_rd [2];
  exp_t        sb0 [$];
  exp_t        sb1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .cs(cs[0]), .wr_en(wr_en[0]), .mask(mask[0]),
    .Mem_Addr(addr[0]), .Mem_inData(wdata[0]), .Mem_outData(mem_out[0]),
    .mem_ready(mem_ready[0]), .busy(busy[0]), .bus_err(bus_err[0])
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .cs(cs[1]), .wr_en(wr_en[1]), .mask(mask[1]),
    .Mem_Addr(addr[1]), .Mem_inData(wdata[1]), .Mem_outData(mem_out[1]),
    .mem_ready(mem_ready[1]), .busy(busy[1]), .bus_err(bus_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_resp(input int d, input exp_t e);
    check($sformatf("rdata%0d", d), mem_out[d], e.data);
    check($sformatf("bus_err%0d", d), 32'(bus_err[d]), 32'(e.err));
    check($sformatf("busy_at_ready%0d", d), 32'(busy[d]), 32'd1);
    check($sformatf("ready_cycle%0d", d), 32'(cyc), 32'(e.cyc));
  endtask

  task automatic unexpected(input int d);
    checks++;
    errors++;
    $display("FAIL unexpected_ready%0d: mem_ready=1 at cycle %0d with nothing outstanding", d, cyc);
  endtask

  always @(negedge clk) begin
    if (mem_ready[0]) begin
      if (sb0.size() == 0) unexpected(0);
      else cmp_resp(0, sb0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (mem_ready[1]) begin
      if (sb1.size() == 0) unexpected(1);
      else cmp_resp(1, sb1.pop_front());
    end
  end

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Called just after a negedge with the DUT idle; returns in the idle cycle after mem_ready.
  task automatic xact(input int d, input logic wr, input logic [3:0] m, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    bit   seen = 1'b0;
    if (!wr) last_rd[d] = exp_rd;
    e.data = last_rd[d];
    e.err  = exp_err;
    e.cyc  = cyc + 1 + wc(d);
    if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    cs[d] = 1'b1; wr_en[d] = wr; mask[d] = m; addr[d] = a; wdata[d] = wd;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_ready[d]) seen = 1'b1;
    end
    cs[d] = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout%0d: no mem_ready for addr %h", d, a);
      if (d == 0) sb0.delete(); else sb1.delete();
    end
    @(negedge clk);
  endtask

  logic [31:0] b2b_addr [4] = '{32'h10, 32'h4, 32'hC, 32'h8};
  logic [31:0] b2b_data [4] = '{32'hF0F0_0004, 32'hA5A5_0001, 32'h0F0F_0003, 32'h5A5A_0002};

  task automatic back_to_back();
    exp_t e;
    int   n = 0;
    int   acc0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      e.data = b2b_data[k];
      e.err  = 1'b0;
      e.cyc  = acc0 + 2 * k;
      sb0.push_back(e);
    end
    last_rd[0] = b2b_data[3];
    cs[0] = 1'b1; wr_en[0] = 1'b0; mask[0] = 4'hF; addr[0] = b2b_addr[0];
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (mem_ready[0]) begin
        n++;
        if (n < 4) addr[0] = b2b_addr[n];
        else cs[0] = 1'b0;
      end
    end
    cs[0] = 1'b0;
    if (n < 4) begin
      checks++;
      errors++;
      $display("FAIL b2b_timeout: got %0d responses expected 4", n);
      sb0.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b1; wr_en[d] = 1'b0; mask[d] = 4'hF; addr[d] = '0; wdata[d] = '0;
      last_rd[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(mem_ready[d]), 32'd0);
      check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst_out%0d", d), mem_out[d], 32'd0);
      check($sformatf("rst_err%0d", d), 32'(bus_err[d]), 32'd0);
      cs[d] = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);

    // WAIT_CYCLES = 2: full write then read
    xact(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xact(1, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // byte lanes 0 and 2 only
    xact(1, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
    xact(1, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 32'h0, 1'b0);
    xact(1, 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB_33DD, 1'b0);
    // mask = 0 write is acknowledged but changes nothing
    xact(1, 1'b1, 4'hF, 32'h40, 32'h5566_7788, 32'h0, 1'b0);
    xact(1, 1'b1, 4'h0, 32'h40, 32'h1234_5678, 32'h0, 1'b0);
    xact(1, 1'b0, 4'hF, 32'h40, 32'h0, 32'h5566_7788, 1'b0);

    // reset on the would-be commit edge discards the pending write
    xact(1, 1'b1, 4'hF, 32'h30, 32'h0BAD_F00D, 32'h0, 1'b0);
    cs[1] = 1'b1; wr_en[1] = 1'b1; mask[1] = 4'hF; addr[1] = 32'h30; wdata[1] = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cs[1] = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(mem_ready[1]), 32'd0);
    check("midrst_busy", 32'(busy[1]), 32'd0);
    check("midrst_out", mem_out[1], 32'd0);
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    xact(1, 1'b0, 4'hF, 32'h30, 32'h0, 32'h0BAD_F00D, 1'b0);

    // out-of-range address
    xact(1, 1'b1, 4'hF, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0);
`ifdef DMEM_BUS_ERR_EN
    xact(1, 1'b0, 4'hF, 32'h1000, 32'h0, 32'h0, 1'b1);
`else
    xact(1, 1'b0, 4'hF, 32'h1000, 32'h0, 32'hCAFE_F00D, 1'b0);
`endif

    // WAIT_CYCLES = 0: prime four words, then back-to-back reads with cs held high
    xact(0, 1'b1, 4'hF, 32'h4, 32'hA5A5_0001, 32'h0, 1'b0);
    xact(0, 1'b1, 4'hF, 32'h8, 32'h5A5A_0002, 32'h0, 1'b0);
    xact(0, 1'b1, 4'hF, 32'hC, 32'h0F0F_0003, 32'h0, 1'b0);
    xact(0, 1'b1, 4'hF, 32'h10, 32'hF0F0_0004, 32'h0, 1'b0);
    back_to_back();

    repeat (3) @(negedge clk);
    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder on the load/store bus driven by the datapath's LSU (cs, wr_en, mask, Mem_Addr, Mem_inData, Mem_outData). It adds a one-cycle completion handshake (mem_ready) and a programmable wait-state count, so the pipelined and multi-cycle cores can stall on memory. Storage is a byte-lane-writable word array, and timing is set by a per-request FSM.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two; ADDR_W = clog2(DEPTH).
- WAIT_CYCLES, 2: wait states between acceptance and response; legal range 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  request valid; held high and stable until mem_ready.
- wr_en  in  1  1 = write, 0 = read; stable while cs is high.
- mask  in  4  write byte enables; mask[i] selects Mem_inData[8i+7:8i]; ignored on reads.
- Mem_Addr  in  32  byte address; word index = Mem_Addr[ADDR_W+1:2]; bits [1:0] ignored.
- Mem_inData  in  32  write data.
- Mem_outData  out  32  registered read data; valid while mem_ready is 1.
- mem_ready  out  1  one-cycle completion pulse, for both reads and writes.
- busy  out  1  high in WAIT and RESP.
- bus_err  out  1  error flag qualified by mem_ready; tied to 0 unless DMEM_BUS_ERR_EN is defined.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If cs = 1, latch wr_en, mask, word index, Mem_inData and the error flag, and load cnt <= WAIT_CYCLES.
  - Next state is RESP if WAIT_CYCLES == 0, otherwise WAIT.
- WAIT: cnt decrements each cycle; on the cycle cnt == 1, next state is RESP.
- Entry to RESP (same edge):
  - Read: the array word is loaded into Mem_outData.
  - Write: every byte lane with latched mask[i] = 1 is committed.
  - Write with mask = 0: no array change, still acknowledged.
  - Writes leave Mem_outData unchanged.
- RESP: mem_ready = 1 for exactly one cycle; next state is IDLE unconditionally.
- Back-to-back: cs still high in the IDLE cycle after RESP starts a new transaction. The requester drops cs in the cycle after mem_ready if it has nothing further.
- Inputs sampled in WAIT/RESP are ignored. Changing a request mid-transaction has no effect on the latched copy.
- Read-after-write to the same word returns the new data, because the write commits before the next acceptance.

## Timing
- The request is accepted at the first rising edge with cs = 1 in IDLE (cycle 0).
- mem_ready is high in cycle WAIT_CYCLES+1. WAIT_CYCLES = 0 gives a response in the cycle after acceptance.
- Minimum request spacing is WAIT_CYCLES+2 cycles.
- mem_ready and busy are decoded from registered state, with no combinational path from the inputs.
- Reset values: state IDLE, cnt 0, Mem_outData 0, mem_ready 0, busy 0, bus_err 0.
- Reset mid-transaction: return to IDLE next cycle. A pending write is discarded and no mem_ready is issued.
- Reset does not clear the storage array; contents are undefined after power-up.
- cs = 1 while reset = 1: ignored. Acceptance starts on the first edge with reset = 0.

## Configuration
- DMEM_BUS_ERR_EN defined:
  - A request is in error if Mem_Addr[31:ADDR_W+2] != 0, or if it is a write with mask = 0 and Mem_Addr[1:0] != 0.
  - On an error, bus_err = 1 together with mem_ready, the write is suppressed and read data is forced to 0. Timing is unchanged.
- DMEM_BUS_ERR_EN undefined: bus_err is held at 0, upper address bits are ignored, and the index wraps modulo DEPTH.

## Structure
- Package dmem_pkg:
  - state enum typedef (IDLE/WAIT/RESP);
  - default DEPTH and WAIT_CYCLES constants;
  - a request struct (wr_en, mask, index, data, err).
- Sub-module dmem_byte_array: synchronous word array with per-byte write enables and a registered read port. It is instantiated once; the FSM and counter stay in data_mem_responder.

## Test plan
- WAIT_CYCLES = 2. Write 0xDEADBEEF to 0x10 with mask 4'hF, then read 0x10 → mem_ready in cycle 3 of each transaction, read returns 0xDEADBEEF.
- Byte masks: word 0x20 = 0x11223344, then write 0xAABBCCDD with mask 4'b0101 → read returns 0x11BB33DD.
- WAIT_CYCLES = 0. Hold cs high for four back-to-back reads → mem_ready every 2nd cycle, busy never low during a transfer.
- Assert reset in WAIT during a write of 0xFFFFFFFF to 0x30 → no mem_ready, outputs return to 0, and a later read of 0x30 shows the old value.
- DMEM_BUS_ERR_EN with DEPTH = 1024: read 0x0000_1000 → mem_ready with bus_err = 1 and Mem_outData = 0. Without the macro → reads word 0, bus_err = 0.
- Write with mask = 0 to 0x40 → mem_ready asserted and a read shows the contents unchanged.
